snake_dir_scheduler: RTL and testbench

//  Turns raw 16-bit keyboard state (two HID keycode slots) into per-player direction commands.

---
 rtl/cobra_key_pkg.sv | 50 +++++
 rtl/dir_queue.sv | 66 ++++++
 rtl/snake_dir_scheduler.sv | 141 ++++++++++++++
 tb/tb_snake_dir_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cobra_key_pkg.sv
// Shared types, HID keycode constants and key-mapping helpers for the
// snake direction scheduler.
package cobra_key_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  localparam logic [7:0] KC_NONE  = 8'h00;
  localparam logic [7:0] KC_W     = 8'h1A;
  localparam logic [7:0] KC_D     = 8'h07;
  localparam logic [7:0] KC_S     = 8'h16;
  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_UP    = 8'h52;
  localparam logic [7:0] KC_RIGHT = 8'h4F;
  localparam logic [7:0] KC_DOWN  = 8'h51;
  localparam logic [7:0] KC_LEFT  = 8'h50;
  localparam logic [7:0] KC_SPACE = 8'h2C;

  // Opposite directions differ only in bit 1 of the encoding.
  function automatic logic is_opposite(dir_t a, dir_t b);
    return ((2'(a) ^ 2'(b)) == 2'b10);
  endfunction

  function automatic logic is_p1_key(logic [7:0] k);
    return (k == KC_W) || (k == KC_D) || (k == KC_S) || (k == KC_A);
  endfunction

  function automatic logic is_p2_key(logic [7:0] k);
    return (k == KC_UP) || (k == KC_RIGHT) || (k == KC_DOWN) || (k == KC_LEFT);
  endfunction

  // Direction for any movement key; unmapped codes return UP and are
  // expected to be masked by is_p1_key/is_p2_key.
  function automatic dir_t key_to_dir(logic [7:0] k);
    dir_t d;
    case (k)
      KC_W, KC_UP:    d = DIR_UP;
      KC_D, KC_RIGHT: d = DIR_RIGHT;
      KC_S, KC_DOWN:  d = DIR_DOWN;
      KC_A, KC_LEFT:  d = DIR_LEFT;
      default:        d = DIR_UP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dir_queue.sv
// Circular FIFO of 2-bit directions. A push into a full queue is accepted
// only when a pop happens in the same cycle; flush empties it immediately.
module dir_queue
  import cobra_key_pkg::*;
#(
  parameter int QDEPTH = 2,
  localparam int CW = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  dir_t          push_dir,
  output dir_t          head,
  output dir_t          tail,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  dir_t          mem [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] last_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full     = (cnt == CW'(QDEPTH));
  assign empty    = (cnt == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign last_ptr = (wr_ptr == '0) ? PW'(QDEPTH - 1) : (wr_ptr - 1'b1);
  assign head     = mem[rd_ptr];
  assign tail     = mem[last_ptr];
  assign count    = cnt;

  // Control stage: pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == PW'(QDEPTH - 1)) ? '0 : (wr_ptr + 1'b1);
      if (do_pop)
        rd_ptr <= (rd_ptr == PW'(QDEPTH - 1)) ? '0 : (rd_ptr + 1'b1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Data stage: storage, left unreset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (!flush && do_push)
      mem[wr_ptr] <= push_dir;
  end

endmodule

// File: rtl/snake_dir_scheduler.sv
// Keyboard-to-direction scheduler for two snake players: detects new key
// presses, maps them to players, filters duplicate/reversal turns, queues
// accepted turns and releases one per player on each step tick.
module snake_dir_scheduler
  import cobra_key_pkg::*;
#(
  parameter int         QDEPTH  = 2,
  parameter logic [1:0] P1_INIT = 2'd1,
  parameter logic [1:0] P2_INIT = 2'd3,
  localparam int        CW      = $clog2(QDEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [15:0]   keycode,
  input  logic          game_en,
  input  logic          step_tick,
  output logic [1:0]    p1_dir,
  output logic [1:0]    p2_dir,
  output logic [CW-1:0] p1_pending,
  output logic [CW-1:0] p2_pending,
  output logic          pause_pulse,
  output logic          drop_pulse
);

  logic [15:0]   kc_p1;
  logic          game_en_p1;
  logic          en_rise;
  logic [7:0]    slot      [2];
  logic          new_press [2];

  dir_t          cur_dir   [2];
  dir_t          init_dir  [2];
  logic          cand_vld  [2];
  dir_t          cand_dir  [2];
  logic          slot_drop [2];
  dir_t          ref_dir   [2];
  logic          accept    [2];
  logic          pop       [2];
  logic          full_drop [2];

  dir_t          q_head    [2];
  dir_t          q_tail    [2];
  logic [CW-1:0] q_count   [2];
  logic          q_full    [2];
  logic          q_empty   [2];

  logic          pause_next;
  logic          drop_next;

  assign init_dir[0] = dir_t'(P1_INIT);
  assign init_dir[1] = dir_t'(P2_INIT);
  assign en_rise     = game_en && !game_en_p1;

  // Press detection: a byte is new only if absent from both previous slots
  always_comb begin
    slot[0] = keycode[7:0];
    slot[1] = keycode[15:8];
    for (int s = 0; s < 2; s++) begin
      new_press[s] = (slot[s] != KC_NONE) &&
                     (slot[s] != kc_p1[7:0]) &&
                     (slot[s] != kc_p1[15:8]);
    end
    pause_next = (new_press[0] && (slot[0] == KC_SPACE)) ||
                 (new_press[1] && (slot[1] == KC_SPACE));
  end

  // Per-player candidate selection, turn filter and queue handshake
  always_comb begin
    drop_next = 1'b0;
    for (int p = 0; p < 2; p++) begin
      logic c0;
      logic c1;
      c0 = new_press[0] && ((p == 0) ? is_p1_key(slot[0]) : is_p2_key(slot[0]));
      c1 = new_press[1] && ((p == 0) ? is_p1_key(slot[1]) : is_p2_key(slot[1]));
      cand_vld[p]  = c0 || c1;
      cand_dir[p]  = c0 ? key_to_dir(slot[0]) : key_to_dir(slot[1]);
      slot_drop[p] = game_en && c0 && c1;
      ref_dir[p]   = q_empty[p] ? cur_dir[p] : q_tail[p];
      accept[p]    = game_en && cand_vld[p] &&
                     (cand_dir[p] != ref_dir[p]) &&
                     !is_opposite(cand_dir[p], ref_dir[p]);
      pop[p]       = game_en && step_tick && !q_empty[p];
      full_drop[p] = accept[p] && q_full[p] && !pop[p];
      drop_next    = drop_next || slot_drop[p] || full_drop[p];
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_queue
    dir_queue #(.QDEPTH(QDEPTH)) u_queue (
      .clk      (Clk),
      .rst      (Reset),
      .flush    (!game_en),
      .push     (accept[g]),
      .pop      (pop[g]),
      .push_dir (cand_dir[g]),
      .head     (q_head[g]),
      .tail     (q_tail[g]),
      .count    (q_count[g]),
      .full     (q_full[g]),
      .empty    (q_empty[g])
    );
  end

  // Stage p1: previous keycode and game_en history for edge detection
  always_ff @(posedge Clk) begin
    if (Reset) begin
      kc_p1      <= '0;
      game_en_p1 <= 1'b1;
    end else begin
      kc_p1      <= keycode;
      game_en_p1 <= game_en;
    end
  end

  // Current directions: reload on enable rise, otherwise take popped head
  always_ff @(posedge Clk) begin
    for (int p = 0; p < 2; p++) begin
      if (Reset || en_rise)
        cur_dir[p] <= init_dir[p];
      else if (pop[p])
        cur_dir[p] <= q_head[p];
    end
  end

  // Registered single-cycle event pulses
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pause_pulse <= 1'b0;
      drop_pulse  <= 1'b0;
    end else begin
      pause_pulse <= pause_next;
      drop_pulse  <= drop_next;
    end
  end

  assign p1_dir     = cur_dir[0];
  assign p2_dir     = cur_dir[1];
  assign p1_pending = q_count[0];
  assign p2_pending = q_count[1];

endmodule

// File: tb/tb_snake_dir_scheduler.sv
// Self-checking bench for snake_dir_scheduler: directed scenarios followed
// by randomized keyboard traffic, all compared to a behavioural model.
module tb_snake_dir_scheduler;

  localparam int QDEPTH = 2;
  localparam int CW     = $clog2(QDEPTH + 1);

  logic          Clk = 1'b0;
  logic          Reset;
  logic [15:0]   keycode;
  logic          game_en;
  logic          step_tick;
  logic [1:0]    p1_dir;
  logic [1:0]    p2_dir;
  logic [CW-1:0] p1_pending;
  logic [CW-1:0] p2_pending;
  logic          pause_pulse;
  logic          drop_pulse;

  int total = 0;
  int bad   = 0;

  snake_dir_scheduler #(.QDEPTH(QDEPTH), .P1_INIT(2'd1), .P2_INIT(2'd3)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .keycode     (keycode),
    .game_en     (game_en),
    .step_tick   (step_tick),
    .p1_dir      (p1_dir),
    .p2_dir      (p2_dir),
    .p1_pending  (p1_pending),
    .p2_pending  (p2_pending),
    .pause_pulse (pause_pulse),
    .drop_pulse  (drop_pulse)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_kc;
  bit          m_en;
  int          mq    [2][QDEPTH];
  int          msz   [2];
  int          md    [2];
  bit          m_pause;
  bit          m_drop;
  int          m_init[2] = '{1, 3};

  function automatic int owner(logic [7:0] b);
    if (b == 8'h1A || b == 8'h07 || b == 8'h16 || b == 8'h04) return 0;
    if (b == 8'h52 || b == 8'h4F || b == 8'h51 || b == 8'h50) return 1;
    return -1;
  endfunction

  function automatic int kdir(logic [7:0] b);
    case (b)
      8'h1A, 8'h52: return 0;
      8'h07, 8'h4F: return 1;
      8'h16, 8'h51: return 2;
      default:      return 3;
    endcase
  endfunction

  function automatic bit is_new(logic [7:0] b, logic [15:0] prev);
    return (b != 8'h00) && (b != prev[7:0]) && (b != prev[15:8]);
  endfunction

  task automatic model_step(input logic [15:0] kc, input bit en, input bit tick, input bit rst);
    logic [7:0] b [2];
    bit         nw [2];
    bit         drop;
    if (rst) begin
      m_kc = 16'h0; m_en = 1'b1; m_pause = 0; m_drop = 0;
      msz[0] = 0; msz[1] = 0; md[0] = m_init[0]; md[1] = m_init[1];
      return;
    end
    b[0] = kc[7:0];
    b[1] = kc[15:8];
    nw[0] = is_new(b[0], m_kc);
    nw[1] = is_new(b[1], m_kc);
    m_pause = (nw[0] && b[0] == 8'h2C) || (nw[1] && b[1] == 8'h2C);
    drop = 0;
    for (int p = 0; p < 2; p++) begin
      if (!en) begin
        msz[p] = 0;
      end else begin
        int cand;
        int n;
        int rf;
        cand = -1;
        n = 0;
        for (int s = 0; s < 2; s++) begin
          if (nw[s] && owner(b[s]) == p) begin
            if (n == 0) cand = kdir(b[s]);
            n++;
          end
        end
        if (n == 2) drop = 1;
        rf = (msz[p] > 0) ? mq[p][msz[p]-1] : md[p];
        if (tick && msz[p] > 0) begin
          md[p] = mq[p][0];
          for (int i = 0; i < QDEPTH - 1; i++) mq[p][i] = mq[p][i+1];
          msz[p]--;
        end
        if (cand >= 0 && cand != rf && cand != (rf ^ 2)) begin
          if (msz[p] < QDEPTH) begin
            mq[p][msz[p]] = cand;
            msz[p]++;
          end else begin
            drop = 1;
          end
        end
        if (!m_en) md[p] = m_init[p];
      end
    end
    m_drop = drop;
    m_kc   = kc;
    m_en   = en;
  endtask

  // One clock: drive, let the edge happen, advance the model, compare
  task automatic cyc(input logic [15:0] kc, input bit en, input bit tick, input bit rst);
    keycode   = kc;
    game_en   = en;
    step_tick = tick;
    Reset     = rst;
    @(posedge Clk);
    model_step(kc, en, tick, rst);
    #1;
    check("p1_dir",      32'(p1_dir),      32'(md[0]));
    check("p2_dir",      32'(p2_dir),      32'(md[1]));
    check("p1_pending",  32'(p1_pending),  32'(msz[0]));
    check("p2_pending",  32'(p2_pending),  32'(msz[1]));
    check("pause_pulse", 32'(pause_pulse), 32'(m_pause));
    check("drop_pulse",  32'(drop_pulse),  32'(m_drop));
  endtask

  logic [7:0] keys [12] = '{8'h00, 8'h00, 8'h1A, 8'h07, 8'h16, 8'h04,
                            8'h52, 8'h4F, 8'h51, 8'h50, 8'h2C, 8'h33};

  initial begin
    logic [15:0] kc;
    bit          en;
    Reset = 1'b1; keycode = '0; game_en = 1'b1; step_tick = 1'b0;

    // Scenario 1: reset values, W press then step tick
    cyc(16'h0000, 1, 0, 1);
    check("rst_p1_dir", 32'(p1_dir), 32'd1);
    check("rst_p2_dir", 32'(p2_dir), 32'd3);
    check("rst_pend", 32'(p1_pending), 32'd0);
    cyc(16'h001A, 1, 0, 0);
    check("t1_push_pend", 32'(p1_pending), 32'd1);
    cyc(16'h0000, 1, 1, 0);
    check("t1_pop_dir", 32'(p1_dir), 32'd0);
    check("t1_pop_pend", 32'(p1_pending), 32'd0);

    // Scenario 2: reversal is rejected silently
    cyc(16'h0000, 1, 0, 1);
    cyc(16'h0004, 1, 0, 0);
    check("t2_rev_pend", 32'(p1_pending), 32'd0);
    check("t2_rev_drop", 32'(drop_pulse), 32'd0);

    // Scenario 3: both players in one keycode word
    cyc(16'h0000, 1, 0, 1);
    cyc(16'h0752, 1, 0, 0);
    check("t3_p1_pend", 32'(p1_pending), 32'd0);
    check("t3_p2_pend", 32'(p2_pending), 32'd1);

    // Scenario 4: overfill the queue
    cyc(16'h0000, 1, 0, 1);
    cyc(16'h001A, 1, 0, 0); cyc(16'h0000, 1, 0, 0);
    cyc(16'h0007, 1, 0, 0); cyc(16'h0000, 1, 0, 0);
    cyc(16'h0016, 1, 0, 0);
    check("t4_full_drop", 32'(drop_pulse), 32'd1);
    check("t4_full_pend", 32'(p1_pending), 32'd2);
    cyc(16'h0000, 1, 0, 0);
    check("t4_drop_clear", 32'(drop_pulse), 32'd0);

    // Scenario 5: push and pop together on a full queue
    cyc(16'h001A, 1, 1, 0);
    check("t5_pend", 32'(p1_pending), 32'd2);
    check("t5_drop", 32'(drop_pulse), 32'd0);
    check("t5_dir", 32'(p1_dir), 32'd0);

    // Two new presses for the same player: slot1 dropped
    cyc(16'h0000, 1, 0, 1);
    cyc(16'h161A, 1, 0, 0);
    check("slot_drop", 32'(drop_pulse), 32'd1);
    check("slot_pend", 32'(p1_pending), 32'd1);

    // Scenario 6: held key, slot swap, game_en flush and reload
    cyc(16'h0000, 1, 0, 1);
    cyc(16'h001A, 1, 0, 0); cyc(16'h001A, 1, 0, 0); cyc(16'h001A, 1, 0, 0);
    cyc(16'h1A00, 1, 0, 0);
    check("t6_hold_pend", 32'(p1_pending), 32'd1);
    cyc(16'h0000, 1, 1, 0);
    check("t6_pop_dir", 32'(p1_dir), 32'd0);
    cyc(16'h0052, 1, 0, 0);
    cyc(16'h0000, 0, 0, 0);
    check("t6_flush_p1", 32'(p1_pending), 32'd0);
    check("t6_flush_p2", 32'(p2_pending), 32'd0);
    cyc(16'h002C, 0, 0, 0);
    check("pause_when_off", 32'(pause_pulse), 32'd1);
    cyc(16'h002C, 1, 0, 0);
    check("pause_one_cycle", 32'(pause_pulse), 32'd0);
    check("t6_reload_p1", 32'(p1_dir), 32'd1);
    check("t6_reload_p2", 32'(p2_dir), 32'd3);

    // Randomized traffic
    kc = 16'h0;
    en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(3) != 0)
        kc = {keys[$urandom_range(11)], keys[$urandom_range(11)]};
      if ($urandom_range(39) == 0) en = !en;
      cyc(kc, en, ($urandom_range(3) == 0), ($urandom_range(299) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
